// File: rtl/alu_md_ctrl_if.sv
// Interface between the main decoder/datapath and the ALU + multiply/divide
// controller. The datapath side drives the instruction fields and operands.
// The controller side returns the ALU control code, the M-extension result,
// and the stall request.
interface alu_md_ctrl_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic            op_b5;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [1:0]      ALUOp;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] md_result;
  logic            md_done;
  logic            stall;

  // Datapath / decoder side
  modport master (
    output valid_i, op_b5, funct3, funct7, ALUOp, src_a, src_b,
    input  alu_control, md_result, md_done, stall
  );

  // Controller side
  modport slave (
    input  valid_i, op_b5, funct3, funct7, ALUOp, src_a, src_b,
    output alu_control, md_result, md_done, stall
  );
endinterface

// File: rtl/alu_md_ctrl.sv
// ALU control decoder with an iterative RV32M multiply/divide unit.
// The decoder is purely combinational. Mul/div/rem run one shift-add or
// restoring-divide step per cycle on operand magnitudes. The sign is applied
// once the last step completes. The datapath is held through the stall output
// until the one-cycle md_done pulse.
module alu_md_ctrl #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         reset,
  alu_md_ctrl_if.slave bus
);

  localparam int               CW      = $clog2(XLEN);
  localparam logic [CW-1:0]    LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_NONE = 4'd15
  } alu_ctrl_t;

  state_t          state, state_next;
  alu_ctrl_t       alu_ctrl;
  logic            is_md;

  // Start-cycle operand conditioning
  logic            sign_a, sign_b, neg_a, neg_b, neg_res;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  // Captured operation and iteration state
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   divisor;
  logic [2:0]        op_f3;
  logic              neg_res_q;
  logic [CW-1:0]     count;

  // One iteration step and the final signed result
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_new;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   div_raw;
  logic [XLEN-1:0]   final_res;

  logic            load_start, load_special, load_final;
  logic [XLEN-1:0] md_result_q;
  logic            md_done_q;

  assign is_md = bus.valid_i & (bus.ALUOp == 2'b10) & bus.op_b5 & (bus.funct7 == 7'b0000001);

  // ALU control decode; M-extension instructions suppress the ALU code
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    alu_ctrl = ALU_NONE;
    if (!is_md) begin
      case (bus.ALUOp)
        2'b00: alu_ctrl = ALU_ADD;
        2'b01: alu_ctrl = ALU_SUB;
        2'b10: begin
          case (bus.funct3)
            3'b000:  alu_ctrl = (bus.op_b5 & bus.funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_ctrl = ALU_SLL;
            3'b010:  alu_ctrl = ALU_SLT;
            3'b011:  alu_ctrl = ALU_SLTU;
            3'b100:  alu_ctrl = ALU_XOR;
            3'b101:  alu_ctrl = bus.funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_ctrl = ALU_OR;
            default: alu_ctrl = ALU_AND;
          endcase
        end
        default: alu_ctrl = ALU_NONE;
      endcase
    end
  end

  assign bus.alu_control = alu_ctrl;

  // Operand signedness, magnitudes and the divide special cases at start
  always_comb begin
    // funct3[2] selects div/rem. For mul, only mulhu leaves rs1 unsigned,
    // and only mul/mulh treat rs2 as signed.
    sign_a   = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3 != 3'b011);
    sign_b   = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
    neg_a    = sign_a & bus.src_a[XLEN-1];
    neg_b    = sign_b & bus.src_b[XLEN-1];
    mag_a    = neg_a ? -bus.src_a : bus.src_a;
    mag_b    = neg_b ? -bus.src_b : bus.src_b;
    // A remainder follows the dividend; products and quotients follow the sign product.
    neg_res  = (bus.funct3[2] & bus.funct3[1]) ? neg_a : (neg_a ^ neg_b);
    div_zero = bus.funct3[2] & (bus.src_b == '0);
    div_ovf  = bus.funct3[2] & ~bus.funct3[0] & (bus.src_a == MIN_INT) & (bus.src_b == '1);
    special  = div_zero | div_ovf;
    if (div_zero) begin
      special_res = bus.funct3[1] ? bus.src_a : '1;
    end else begin
      special_res = bus.funct3[1] ? '0 : bus.src_a;
    end
  end

  // One mul or div iteration, plus sign correction and field selection of the result
  always_comb begin
    // Multiply: add the multiplicand into the upper half when the low bit is set, then shift right.
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, divisor} : '0);
    // Divide: the upper half is the partial remainder and the lower half shifts dividend bits out and quotient bits in.
    // A carry into bit XLEN means the shifted remainder already exceeds any XLEN-bit divisor.
    rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    rem_ge  = rem_sh[XLEN] | (rem_sh[XLEN-1:0] >= divisor);
    rem_new = rem_ge ? (rem_sh[XLEN-1:0] - divisor) : rem_sh[XLEN-1:0];
    if (op_f3[2]) begin
      acc_next = {rem_new, acc[XLEN-2:0], rem_ge};
    end else begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
    end

    prod_fixed = neg_res_q ? -acc_next : acc_next;
    div_raw    = op_f3[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
    if (op_f3[2]) begin
      final_res = neg_res_q ? -div_raw : div_raw;
    end else if (op_f3[1:0] == 2'b00) begin
      final_res = prod_fixed[XLEN-1:0];
    end else begin
      final_res = prod_fixed[2*XLEN-1:XLEN];
    end
  end

  // Next-state logic and load strobes
  always_comb begin
    state_next   = state;
    load_start   = 1'b0;
    load_special = 1'b0;
    load_final   = 1'b0;
    case (state)
      IDLE: begin
        if (is_md) begin
          load_start = 1'b1;
          if (special) begin
            load_special = 1'b1;
            state_next   = DONE;
          end else begin
            state_next   = BUSY;
          end
        end
      end
      BUSY: begin
        if (count == LAST) begin
          load_final = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values regardless of block order.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Step counter and the registered result/done outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      md_done_q   <= 1'b0;
      md_result_q <= '0;
    end else begin
      if (load_start) begin
        count <= '0;
      end else if (state == BUSY) begin
        count <= count + CW'(1);
      end
      md_done_q <= load_special | load_final;
      if (load_special) begin
        md_result_q <= special_res;
      end else if (load_final) begin
        md_result_q <= final_res;
      end
    end
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk) begin
    // NOTE: these registers have no reset. They are always written by load_start before anything reads them.
    if (load_start) begin
      acc       <= {{XLEN{1'b0}}, mag_a};
      divisor   <= mag_b;
      op_f3     <= bus.funct3;
      neg_res_q <= neg_res;
    end else if (state == BUSY) begin
      acc <= acc_next;
    end
  end

  assign bus.md_result = md_result_q;
  assign bus.md_done   = md_done_q;
  assign bus.stall     = is_md & (state != DONE);

endmodule

// File: tb/tb_alu_md_ctrl.sv
// Testbench for alu_md_ctrl at XLEN=32. A compare process checks every cycle
// against a behavioural model built on 64-bit arithmetic. Directed vectors
// with hand-computed values pin the model itself.
module tb_alu_md_ctrl;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_md_ctrl_if #(.XLEN(XLEN)) bus ();

  alu_md_ctrl #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks      = 0;
  int          n_fail        = 0;
  int          cyc           = 0;
  int          exp_done_at   = -1;
  logic [31:0] exp_res       = '0;
  int          last_done_cyc = -1;
  logic [31:0] last_result   = '0;
  int          stall_cnt     = 0;
  bit          checking      = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ALU control code from the instruction fields
  function automatic logic [3:0] ref_ctrl(input logic v, input logic b5, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [1:0] op);
    if (v && op == 2'b10 && b5 && f7 == 7'b0000001) return 4'd15;
    case (op)
      2'b00: return 4'd0;
      2'b01: return 4'd1;
      2'b11: return 4'd15;
      default: begin
        case (f3)
          3'b000:  return (b5 && f7[5]) ? 4'd1 : 4'd0;
          3'b111:  return 4'd2;
          3'b110:  return 4'd3;
          3'b100:  return 4'd4;
          3'b010:  return 4'd5;
          3'b011:  return 4'd9;
          3'b001:  return 4'd6;
          default: return f7[5] ? 4'd8 : 4'd7;
        endcase
      end
    endcase
  endfunction

  // RV32M result by 64-bit integer arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = int'(a);
    ib = int'(b);
    case (f3)
      3'b000: begin p = 64'(sa * sb); return p[31:0]; end
      3'b001: begin p = 64'(sa * sb); return p[63:32]; end
      3'b010: begin p = 64'(sa * ub); return p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (checking && !reset) begin
      logic is_md_e;
      is_md_e = bus.valid_i && bus.ALUOp == 2'b10 && bus.op_b5 && bus.funct7 == 7'b0000001;
      check("alu_control", 32'(bus.alu_control),
            32'(ref_ctrl(bus.valid_i, bus.op_b5, bus.funct3, bus.funct7, bus.ALUOp)));
      check("stall", 32'(bus.stall), 32'(is_md_e && cyc != exp_done_at));
      check("md_done", 32'(bus.md_done), 32'(cyc == exp_done_at));
      if (cyc == exp_done_at) check("md_result", bus.md_result, exp_res);
      if (bus.md_done === 1'b1) begin
        last_result   = bus.md_result;
        last_done_cyc = cyc;
      end
      if (bus.stall === 1'b1) stall_cnt++;
    end
  end

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic       b5;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] exp;
  } dec_t;

  dec_t dec_tab [14] = '{
    '{1'b1, 2'b10, 1'b1, 3'b101, 7'h20, 4'd8},
    '{1'b1, 2'b10, 1'b1, 3'b011, 7'h20, 4'd9},
    '{1'b1, 2'b11, 1'b1, 3'b000, 7'h00, 4'd15},
    '{1'b1, 2'b00, 1'b0, 3'b000, 7'h00, 4'd0},
    '{1'b1, 2'b01, 1'b0, 3'b000, 7'h00, 4'd1},
    '{1'b1, 2'b10, 1'b1, 3'b000, 7'h20, 4'd1},
    '{1'b1, 2'b10, 1'b0, 3'b000, 7'h20, 4'd0},
    '{1'b1, 2'b10, 1'b1, 3'b101, 7'h00, 4'd7},
    '{1'b1, 2'b10, 1'b1, 3'b001, 7'h00, 4'd6},
    '{1'b1, 2'b10, 1'b1, 3'b010, 7'h00, 4'd5},
    '{1'b1, 2'b10, 1'b1, 3'b111, 7'h00, 4'd2},
    '{1'b1, 2'b10, 1'b1, 3'b110, 7'h00, 4'd3},
    '{1'b1, 2'b10, 1'b1, 3'b100, 7'h00, 4'd4},
    '{1'b0, 2'b10, 1'b1, 3'b000, 7'h01, 4'd0}
  };

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lit;
    bit          special;
  } md_t;

  md_t md_tab [15] = '{
    '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0},
    '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0},
    '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0},
    '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0},
    '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0},
    '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0},
    '{3'b101, 32'd100,       32'd7,         32'd14,        1'b0},
    '{3'b111, 32'd100,       32'd7,         32'd2,         1'b0},
    '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1},
    '{3'b110, 32'd5,         32'd0,         32'd5,         1'b1},
    '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1},
    '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1},
    '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0},
    '{3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0},
    '{3'b101, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1'b1}
  };

  // Present one M instruction, hold it while stalled, then check latency, stall length and result
  task automatic run_md(input string name, input md_t t);
    int s;
    int lat;
    lat = t.special ? 1 : XLEN + 1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b1;
    bus.ALUOp   = 2'b10;
    bus.op_b5   = 1'b1;
    bus.funct7  = 7'b0000001;
    bus.funct3  = t.f3;
    bus.src_a   = t.a;
    bus.src_b   = t.b;
    s             = cyc;
    exp_done_at   = s + lat;
    exp_res       = ref_md(t.f3, t.a, t.b);
    last_done_cyc = -1;
    stall_cnt     = 0;
    for (int i = 0; i < lat; i++) begin
      @(posedge clk);
      #1;
      if (!t.special && cyc == s + 2) begin
        bus.src_a = ~t.a;
        bus.src_b = 32'h5A5A_5A5A;
      end
    end
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    @(negedge clk);
    check({name, " latency"}, 32'(last_done_cyc - s), 32'(lat));
    check({name, " stall cycles"}, 32'(stall_cnt), 32'(lat));
    check({name, " result"}, last_result, t.lit);
  endtask

  initial begin
    int s;
    bus.valid_i = 1'b0;
    bus.ALUOp   = 2'b00;
    bus.op_b5   = 1'b0;
    bus.funct3  = 3'b000;
    bus.funct7  = 7'h00;
    bus.src_a   = '0;
    bus.src_b   = '0;

    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b0;
    checking = 1'b1;
    @(negedge clk);
    check("reset md_done", 32'(bus.md_done), 32'd0);
    check("reset md_result", bus.md_result, 32'd0);
    check("reset stall", 32'(bus.stall), 32'd0);

    // Decode sweep
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      bus.valid_i = dec_tab[i].v;
      bus.ALUOp   = dec_tab[i].op;
      bus.op_b5   = dec_tab[i].b5;
      bus.funct3  = dec_tab[i].f3;
      bus.funct7  = dec_tab[i].f7;
      @(negedge clk);
      check($sformatf("decode[%0d] alu_control", i), 32'(bus.alu_control), 32'(dec_tab[i].exp));
      check($sformatf("decode[%0d] stall", i), 32'(bus.stall), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;

    // Multiply / divide vectors
    for (int i = 0; i < 15; i++) begin
      run_md($sformatf("md[%0d]", i), md_tab[i]);
    end

    // Reset in the middle of a multiply drops it without an md_done pulse
    @(posedge clk);
    #1;
    bus.valid_i   = 1'b1;
    bus.ALUOp     = 2'b10;
    bus.op_b5     = 1'b1;
    bus.funct7    = 7'b0000001;
    bus.funct3    = 3'b000;
    bus.src_a     = 32'h0000_0007;
    bus.src_b     = 32'hFFFF_FFFD;
    s             = cyc;
    exp_done_at   = s + XLEN + 1;
    exp_res       = ref_md(3'b000, 32'h0000_0007, 32'hFFFF_FFFD);
    last_done_cyc = -1;
    repeat (10) @(posedge clk);
    #1;
    reset       = 1'b1;
    bus.valid_i = 1'b0;
    exp_done_at = -1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort md_result", bus.md_result, 32'd0);
    check("abort md_done", 32'(bus.md_done), 32'd0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("abort no done pulse", 32'(last_done_cyc), 32'hFFFF_FFFF);

    // A fresh multiply after the abort completes normally
    run_md("post-abort mul", md_tab[0]);
    run_md("back-to-back mulhu", md_tab[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end within the time limit");
    $fatal(1, "timeout");
  end

endmodule
